// File: rtl/led_pio_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// led_pio_write_arbiter_if
//
// Purpose:
//   Bundles the requester handshake and the Avalon-MM write port of the LED
//   PIO arbiter so both can be passed around as a single port.
//
// Signals:
//   req            NUM_REQ        per-requester write request (level)
//   req_data       NUM_REQ*WIDTH  requester i value in [i*WIDTH +: WIDTH]
//   ack            NUM_REQ        one-cycle grant/complete pulse
//   avm_address    2              Avalon word address to the PIO
//   avm_chipselect 1              Avalon chipselect to the PIO
//   avm_write_n    1              Avalon write strobe, active low
//   avm_writedata  32             Avalon write data, value zero-extended
//   led_value      WIDTH          shadow of the last value written
//   busy           1              arbiter is writing or in its gap
//
// Modports:
//   master  the requester side: drives req/req_data, observes the rest
//   slave   the arbiter side: consumes req/req_data, drives the rest
// ---------------------------------------------------------------------------
interface led_pio_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 14
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       ack;
    logic [1:0]               avm_address;
    logic                     avm_chipselect;
    logic                     avm_write_n;
    logic [31:0]              avm_writedata;
    logic [WIDTH-1:0]         led_value;
    logic                     busy;

    modport master (
        output req,
        output req_data,
        input  ack,
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        input  led_value,
        input  busy
    );

    modport slave (
        input  req,
        input  req_data,
        output ack,
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        output led_value,
        output busy
    );
endinterface

// File: rtl/led_pio_write_arbiter.sv
// ---------------------------------------------------------------------------
// led_pio_write_arbiter
//
// Purpose:
//   Shares one LED PIO Avalon-MM slave between NUM_REQ requesters. Requests
//   are granted round-robin; each grant produces exactly one single-cycle
//   Avalon write of the requester's value, followed by GAP_CYCLES idle
//   cycles before the next arbitration. A shadow of the last written value
//   is kept on led_value.
//
// Parameters:
//   NUM_REQ     number of requesters (2..8)
//   WIDTH       LED value width, equal to the PIO data register width
//   GAP_CYCLES  idle cycles after each write (0..255)
//   PIO_ADDR    Avalon word address of the PIO data register
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    slave modport of led_pio_write_arbiter_if (handshake + Avalon)
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module led_pio_write_arbiter #(
    parameter int         NUM_REQ    = 4,
    parameter int         WIDTH      = 14,
    parameter int         GAP_CYCLES = 2,
    parameter logic [1:0] PIO_ADDR   = 2'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    led_pio_write_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // The gap counter is loaded with GAP_CYCLES-1 on leaving WRITE and
    // counts down to zero, so GAP lasts exactly GAP_CYCLES cycles.
    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t               state_q,      state_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic [7:0]           gap_cnt_q,    gap_cnt_d;
    logic [WIDTH-1:0]     data_q,       data_d;
    logic [NUM_REQ-1:0]   ack_q,        ack_d;
    logic                 cs_q,         cs_d;
    logic                 write_n_q,    write_n_d;
    logic [1:0]           addr_q,       addr_d;
    logic [31:0]          wdata_q,      wdata_d;
    logic [WIDTH-1:0]     led_q,        led_d;
    logic                 busy_q,       busy_d;

    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [WIDTH-1:0]     pick_data;

    // Requester index reached by stepping 'off' places past 'base' with wrap.
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                  input int               off);
        return IDX_W'((int'(base) + off) % NUM_REQ);
    endfunction

    // Round-robin pick: scan from the requester after the last grant,
    // upward with wrap, and stop at the first active request. The last
    // granted requester is scanned last, so it only wins again when it is
    // the only one asking.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!pick_valid && bus.req[rr_index(last_grant_q, off)]) begin
                pick_valid = 1'b1;
                pick_idx   = rr_index(last_grant_q, off);
            end
        end
        pick_data = bus.req_data[int'(pick_idx)*WIDTH +: WIDTH];
    end

    // Next-state and next-output logic. Because every output is registered,
    // the bus values for the WRITE cycle are prepared while still in IDLE,
    // and the value latched at grant time is what gets written, so later
    // changes to req_data cannot disturb the write in progress. busy follows
    // the state that is about to be entered.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gap_cnt_d    = gap_cnt_q;
        data_d       = data_q;
        ack_d        = '0;
        cs_d         = 1'b0;
        write_n_d    = 1'b1;
        addr_d       = 2'd0;
        wdata_d      = 32'd0;
        led_d        = led_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d         = WRITE;
                    last_grant_d    = pick_idx;
                    data_d          = pick_data;
                    ack_d[pick_idx] = 1'b1;
                    cs_d            = 1'b1;
                    write_n_d       = 1'b0;
                    addr_d          = PIO_ADDR;
                    wdata_d         = 32'(pick_data);
                end
            end
            WRITE: begin
                led_d = data_q;
                if (GAP_CYCLES > 0) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers. Reset forces the idle bus and restarts the
    // round-robin pointer so that requester 0 is scanned first; a write that
    // would have started on the reset edge is simply never issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            gap_cnt_q    <= 8'd0;
            data_q       <= '0;
            ack_q        <= '0;
            cs_q         <= 1'b0;
            write_n_q    <= 1'b1;
            addr_q       <= 2'd0;
            wdata_q      <= 32'd0;
            led_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gap_cnt_q    <= gap_cnt_d;
            data_q       <= data_d;
            ack_q        <= ack_d;
            cs_q         <= cs_d;
            write_n_q    <= write_n_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            led_q        <= led_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.ack            = ack_q;
    assign bus.avm_chipselect = cs_q;
    assign bus.avm_write_n    = write_n_q;
    assign bus.avm_address    = addr_q;
    assign bus.avm_writedata  = wdata_q;
    assign bus.led_value      = led_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_led_pio_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_led_pio_write_arbiter
//
// Drives two arbiters from the same requester signals: dut_a with a 2-cycle
// gap at address 0 and dut_b with no gap at address 3. Every cycle both are
// compared against a timeline model of the arbiter (when it is next free to
// arbitrate, who was granted last, what was last written). On top of that a
// table of directed vectors and a few hand-written sequences pin down exact
// cycle-by-cycle values for dut_a and dut_b.
// ---------------------------------------------------------------------------
module tb_led_pio_write_arbiter;

    localparam int         NR     = 4;
    localparam int         W      = 14;
    localparam int         DW     = NR * W;
    localparam int         GAP_A  = 2;
    localparam int         GAP_B  = 0;
    localparam logic [1:0] ADDR_A = 2'd0;
    localparam logic [1:0] ADDR_B = 2'd3;

    localparam logic [DW-1:0] D_NONE = '0;
    localparam logic [DW-1:0] D_T2   = {14'h0000, 14'h1555, 14'h0000, 14'h0000};
    localparam logic [DW-1:0] D_ALL  = {14'h0008, 14'h0004, 14'h0002, 14'h0001};
    localparam logic [DW-1:0] D_T5   = {14'h0000, 14'h0000, 14'h3FFF, 14'h0000};
    localparam logic [DW-1:0] D_T6   = {14'h0000, 14'h0000, 14'h2AAA, 14'h0000};

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    led_pio_write_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus_a ();
    led_pio_write_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus_b ();

    led_pio_write_arbiter #(
        .NUM_REQ(NR), .WIDTH(W), .GAP_CYCLES(GAP_A), .PIO_ADDR(ADDR_A)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    led_pio_write_arbiter #(
        .NUM_REQ(NR), .WIDTH(W), .GAP_CYCLES(GAP_B), .PIO_ADDR(ADDR_B)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // Expected visible behaviour of one arbiter in one cycle.
    typedef struct {
        bit              write;
        logic [W-1:0]    data;
        logic [NR-1:0]   ack;
        logic [W-1:0]    led;
        bit              busy;
    } exp_t;

    // One directed vector: inputs for a cycle and dut_a's outputs one cycle later.
    typedef struct {
        bit              rst;
        logic [NR-1:0]   req;
        logic [DW-1:0]   data;
        bit              cs;
        logic [31:0]     wd;
        logic [NR-1:0]   ack;
        logic [W-1:0]    led;
        bit              busy;
    } vec_t;

    exp_t cur[2];
    int   t_now[2];
    int   idle_from[2];
    int   last[2];
    vec_t vecs[$];

    int errors = 0;
    int checks = 0;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: the arbiter may arbitrate in cycle t only when
    // t >= idle_from; a grant in cycle t writes in t+1 and frees the arbiter
    // again at t+2+gap. Computes expected outputs for the cycle after t.
    task automatic modelStep(input int k, input int gap, input bit rst,
                             input logic [NR-1:0] r, input logic [DW-1:0] d);
        exp_t nxt;
        int   win;
        nxt.write = 1'b0;
        nxt.data  = '0;
        nxt.ack   = '0;
        nxt.busy  = 1'b0;
        nxt.led   = '0;
        if (rst) begin
            last[k]      = NR - 1;
            idle_from[k] = t_now[k] + 1;
        end else begin
            nxt.led = cur[k].write ? cur[k].data : cur[k].led;
            if (t_now[k] >= idle_from[k] && r != '0) begin
                win = -1;
                for (int s = 1; s <= NR; s++) begin
                    if (win < 0 && r[(last[k] + s) % NR]) win = (last[k] + s) % NR;
                end
                nxt.write    = 1'b1;
                nxt.data     = d[win*W +: W];
                nxt.ack      = NR'(1) << win;
                last[k]      = win;
                idle_from[k] = t_now[k] + 2 + gap;
            end
            nxt.busy = (t_now[k] + 1 < idle_from[k]);
        end
        cur[k] = nxt;
        t_now[k]++;
    endtask

    task automatic checkDut(input string tag, input int k, input logic [1:0] addr_exp,
                            input logic cs, input logic wn, input logic [1:0] addr,
                            input logic [31:0] wd, input logic [NR-1:0] ack,
                            input logic [W-1:0] led, input logic busy);
        checkValue({tag, ".cs"},   32'(cs),   32'(cur[k].write));
        checkValue({tag, ".wn"},   32'(wn),   32'(!cur[k].write));
        checkValue({tag, ".addr"}, 32'(addr), cur[k].write ? 32'(addr_exp) : 32'd0);
        checkValue({tag, ".wd"},   wd,        cur[k].write ? 32'(cur[k].data) : 32'd0);
        checkValue({tag, ".ack"},  32'(ack),  32'(cur[k].ack));
        checkValue({tag, ".led"},  32'(led),  32'(cur[k].led));
        checkValue({tag, ".busy"}, 32'(busy), 32'(cur[k].busy));
    endtask

    task automatic checkOutput();
        checkDut("a", 0, ADDR_A, bus_a.avm_chipselect, bus_a.avm_write_n, bus_a.avm_address,
                 bus_a.avm_writedata, bus_a.ack, bus_a.led_value, bus_a.busy);
        checkDut("b", 1, ADDR_B, bus_b.avm_chipselect, bus_b.avm_write_n, bus_b.avm_address,
                 bus_b.avm_writedata, bus_b.ack, bus_b.led_value, bus_b.busy);
    endtask

    // Called at a falling edge: drive one cycle of inputs, advance the model,
    // then sample both arbiters at the next falling edge.
    task automatic applyStimulus(input bit rst, input logic [NR-1:0] r, input logic [DW-1:0] d);
        reset          = rst;
        bus_a.req      = r;
        bus_b.req      = r;
        bus_a.req_data = d;
        bus_b.req_data = d;
        modelStep(0, GAP_A, rst, r, d);
        modelStep(1, GAP_B, rst, r, d);
        @(negedge clk);
        checkOutput();
    endtask

    function automatic void addVec(input bit rst, input logic [NR-1:0] req, input logic [DW-1:0] data,
                                   input bit cs, input logic [31:0] wd, input logic [NR-1:0] ack,
                                   input logic [W-1:0] led, input bit busy);
        vec_t v;
        v.rst = rst; v.req = req; v.data = data;
        v.cs = cs; v.wd = wd; v.ack = ack; v.led = led; v.busy = busy;
        vecs.push_back(v);
    endfunction

    initial begin
        // Single write of 14'h1555 by requester 2, then its gap.
        addVec(1'b1, 4'b0000, D_NONE, 1'b0, 32'h0,        4'b0000, 14'h0000, 1'b0);
        addVec(1'b0, 4'b0100, D_T2,   1'b1, 32'h00001555, 4'b0100, 14'h0000, 1'b1);
        addVec(1'b0, 4'b0000, D_T2,   1'b0, 32'h0,        4'b0000, 14'h1555, 1'b1);
        addVec(1'b0, 4'b0000, D_T2,   1'b0, 32'h0,        4'b0000, 14'h1555, 1'b1);
        addVec(1'b0, 4'b0000, D_T2,   1'b0, 32'h0,        4'b0000, 14'h1555, 1'b0);
        // All four requesting continuously: 1,2,4,8,1 four cycles apart.
        addVec(1'b1, 4'b0000, D_ALL,  1'b0, 32'h0,        4'b0000, 14'h0000, 1'b0);
        addVec(1'b0, 4'b1111, D_ALL,  1'b1, 32'h00000001, 4'b0001, 14'h0000, 1'b1);
        addVec(1'b0, 4'b1111, D_ALL,  1'b0, 32'h0,        4'b0000, 14'h0001, 1'b1);
        addVec(1'b0, 4'b1111, D_ALL,  1'b0, 32'h0,        4'b0000, 14'h0001, 1'b1);
        addVec(1'b0, 4'b1111, D_ALL,  1'b0, 32'h0,        4'b0000, 14'h0001, 1'b0);
        addVec(1'b0, 4'b1111, D_ALL,  1'b1, 32'h00000002, 4'b0010, 14'h0001, 1'b1);
        addVec(1'b0, 4'b1111, D_ALL,  1'b0, 32'h0,        4'b0000, 14'h0002, 1'b1);
        addVec(1'b0, 4'b1111, D_ALL,  1'b0, 32'h0,        4'b0000, 14'h0002, 1'b1);
        addVec(1'b0, 4'b1111, D_ALL,  1'b0, 32'h0,        4'b0000, 14'h0002, 1'b0);
        addVec(1'b0, 4'b1111, D_ALL,  1'b1, 32'h00000004, 4'b0100, 14'h0002, 1'b1);
        addVec(1'b0, 4'b1111, D_ALL,  1'b0, 32'h0,        4'b0000, 14'h0004, 1'b1);
        addVec(1'b0, 4'b1111, D_ALL,  1'b0, 32'h0,        4'b0000, 14'h0004, 1'b1);
        addVec(1'b0, 4'b1111, D_ALL,  1'b0, 32'h0,        4'b0000, 14'h0004, 1'b0);
        addVec(1'b0, 4'b1111, D_ALL,  1'b1, 32'h00000008, 4'b1000, 14'h0004, 1'b1);
        addVec(1'b0, 4'b1111, D_ALL,  1'b0, 32'h0,        4'b0000, 14'h0008, 1'b1);
        addVec(1'b0, 4'b1111, D_ALL,  1'b0, 32'h0,        4'b0000, 14'h0008, 1'b1);
        addVec(1'b0, 4'b1111, D_ALL,  1'b0, 32'h0,        4'b0000, 14'h0008, 1'b0);
        addVec(1'b0, 4'b1111, D_ALL,  1'b1, 32'h00000001, 4'b0001, 14'h0008, 1'b1);
        addVec(1'b0, 4'b0000, D_ALL,  1'b0, 32'h0,        4'b0000, 14'h0001, 1'b1);

        @(negedge clk);

        // Reset held three cycles with every requester asking, then release.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b1111, D_ALL);
        applyStimulus(1'b0, 4'b1111, D_ALL);
        checkValue("t1.first_grant", 32'(bus_a.ack), 32'(4'b0001));

        // Directed vector table against dut_a.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].data);
            checkValue($sformatf("vec%0d.cs", i),   32'(bus_a.avm_chipselect), 32'(vecs[i].cs));
            checkValue($sformatf("vec%0d.wn", i),   32'(bus_a.avm_write_n),    32'(!vecs[i].cs));
            checkValue($sformatf("vec%0d.addr", i), 32'(bus_a.avm_address),    32'd0);
            checkValue($sformatf("vec%0d.wd", i),   bus_a.avm_writedata,       vecs[i].wd);
            checkValue($sformatf("vec%0d.ack", i),  32'(bus_a.ack),            32'(vecs[i].ack));
            checkValue($sformatf("vec%0d.led", i),  32'(bus_a.led_value),      32'(vecs[i].led));
            checkValue($sformatf("vec%0d.busy", i), 32'(bus_a.busy),           32'(vecs[i].busy));
        end

        // Requester 3 raised during requester 0's gap wins the next slot.
        applyStimulus(1'b1, 4'b0000, D_ALL);
        applyStimulus(1'b0, 4'b0001, D_ALL);
        checkValue("t4.first.ack", 32'(bus_a.ack), 32'(4'b0001));
        applyStimulus(1'b0, 4'b0001, D_ALL);
        applyStimulus(1'b0, 4'b1001, D_ALL);
        applyStimulus(1'b0, 4'b1001, D_ALL);
        applyStimulus(1'b0, 4'b1001, D_ALL);
        checkValue("t4.req3.wd",  bus_a.avm_writedata, 32'h00000008);
        checkValue("t4.req3.ack", 32'(bus_a.ack),      32'(4'b1000));
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b0001, D_ALL);
        checkValue("t4.req0.wd",  bus_a.avm_writedata, 32'h00000001);
        checkValue("t4.req0.ack", 32'(bus_a.ack),      32'(4'b0001));

        // Reset in the second gap cycle after writing 14'h3FFF.
        applyStimulus(1'b1, 4'b0000, D_T5);
        applyStimulus(1'b0, 4'b0010, D_T5);
        checkValue("t5.wd", bus_a.avm_writedata, 32'h00003FFF);
        applyStimulus(1'b0, 4'b0010, D_T5);
        applyStimulus(1'b0, 4'b0010, D_T5);
        checkValue("t5.led_before", 32'(bus_a.led_value), 32'h3FFF);
        applyStimulus(1'b1, 4'b0010, D_T5);
        checkValue("t5.led_reset",  32'(bus_a.led_value), 32'h0);
        checkValue("t5.busy_reset", 32'(bus_a.busy),      32'h0);
        applyStimulus(1'b0, 4'b0010, D_T5);
        checkValue("t5.rewrite.cs",  32'(bus_a.avm_chipselect), 32'h1);
        checkValue("t5.rewrite.ack", 32'(bus_a.ack),            32'(4'b0010));

        // No gap: requester 1 held writes every other cycle on dut_b.
        applyStimulus(1'b1, 4'b0000, D_T6);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 4'b0010, D_T6);
            checkValue($sformatf("t6.ack%0d", i),  32'(bus_b.ack),  (i % 2 == 0) ? 32'h2 : 32'h0);
            checkValue($sformatf("t6.busy%0d", i), 32'(bus_b.busy), (i % 2 == 0) ? 32'h1 : 32'h0);
            checkValue($sformatf("t6.wd%0d", i),   bus_b.avm_writedata,
                       (i % 2 == 0) ? 32'h00002AAA : 32'h0);
            checkValue($sformatf("t6.addr%0d", i), 32'(bus_b.avm_address),
                       (i % 2 == 0) ? 32'(ADDR_B) : 32'h0);
        end

        // Random requests, data and occasional resets against the model.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 63) == 0, NR'($urandom), DW'({$urandom, $urandom}));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_pio_write_arbiter.md
Name: led_pio_write_arbiter

Overview:
- Shares the single 14-bit LED PIO Avalon-MM slave among NUM_REQ independent requesters, e.g. game FSM, score logic and debug.
- Each requester presents a value with a req/ack handshake.
- The arbiter grants round-robin and issues one Avalon write to the PIO data register per grant.
- It enforces a minimum gap between writes and keeps a shadow copy of the last value written.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 14, LED value width; must match the PIO data register width
GAP_CYCLES, 2, idle cycles inserted after each write before the next arbitration (0..255)
PIO_ADDR, 0, 2-bit Avalon word address of the PIO data register

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester write request, level
req_data  input  NUM_REQ*WIDTH  requester i value in bits [i*WIDTH +: WIDTH]
ack  output  NUM_REQ  one-cycle grant/complete pulse per requester
avm_address  output  2  to PIO address
avm_chipselect  output  1  to PIO chipselect
avm_write_n  output  1  to PIO write_n, active low
avm_writedata  output  32  to PIO writedata; value zero-extended
led_value  output  WIDTH  shadow of the last value written to the PIO
busy  output  1  high in WRITE and GAP states

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset). All outputs are registered.
- Reset values:
  - state=IDLE, last_grant=NUM_REQ-1, gap counter 0
  - avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0
  - ack=0, led_value=0, busy=0
- State IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise pick the first set req bit scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - Latch that requester's req_data and index, update last_grant, go to WRITE.
- State WRITE (exactly 1 cycle):
  - avm_chipselect=1, avm_write_n=0, avm_address=PIO_ADDR.
  - avm_writedata = {(32-WIDTH) zeros, latched data}.
  - ack[granted]=1 in this cycle only.
  - Next: GAP if GAP_CYCLES>0, else IDLE.
  - led_value takes the latched data at the end of WRITE (visible from the following cycle).
- State GAP:
  - Bus outputs idle: chipselect=0, write_n=1, writedata=0.
  - Lasts exactly GAP_CYCLES cycles, then IDLE.
  - req is ignored in GAP.
- Latency:
  - req sampled high in IDLE cycle N gives WRITE and ack in cycle N+1.
  - Minimum write-to-write spacing is GAP_CYCLES+2 cycles.
- Handshake:
  - Requester holds req and req_data stable until it sees ack, then drops req.
  - req still high in the IDLE cycle after the write completes is a new request.
  - req dropped before grant: nothing is written.
  - req_data changes after grant do not affect the write in progress.
- Simultaneous requests: strictly round-robin, so no requester waits more than NUM_REQ grants.
- PIO has no waitrequest; a write always completes in the WRITE cycle.
- Reset mid-operation (WRITE or GAP): the next cycle has reset values; no ack is issued for an aborted WRITE if reset coincides with it; pending requests are re-arbitrated from requester 0.
- ack is never asserted for more than one requester or for more than one cycle.

Test Plan:
1. Assert reset 3 cycles with req=4'b1111 -> chipselect=0, write_n=1, ack=0, led_value=0, busy=0 throughout; first grant after release is requester 0.
2. req[2]=1, data2=14'h1555 in IDLE cycle N -> cycle N+1: chipselect=1, write_n=0, address=0, writedata=32'h00001555, ack=4'b0100; led_value=14'h1555 from N+2; busy high N+1..N+3; IDLE at N+4.
3. All four req held continuously with data 1,2,4,8 and GAP_CYCLES=2 -> writedata sequence 1,2,4,8,1 on writes 4 cycles apart; ack one-hot 0001,0010,0100,1000,0001.
4. req0 held continuously; req3 raised during req0's GAP -> next write is requester 3 (14'h0008), then requester 0.
5. reset asserted in the second GAP cycle after a write of 14'h3FFF -> next cycle led_value=0, state IDLE; held req1 then writes 1 cycle after reset release.
6. GAP_CYCLES=0, req1 held with data 14'h2AAA -> writes every 2 cycles, ack[1] pulsing every other cycle, busy toggling 1/0.
